// File: rtl/clock_gen_pkg.sv
// Shared definitions for the clock-enable generator: FSM encoding,
// parameter defaults and a small index-width helper.
package clock_gen_pkg;

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        SETTLE    = 2'd1,
        RUN       = 2'd2
    } state_t;

    localparam int DEF_NUM_CH      = 4;
    localparam int DEF_ACC_WIDTH   = 24;
    localparam int DEF_LOCK_CYCLES = 1024;
    localparam int DEF_INC         = 1;

    // Width of an index into n items, never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/phase_acc.sv
// Single-channel phase accumulator: holds its own increment register and
// emits the carry-out of each accumulation as a registered enable pulse.
module phase_acc
    import clock_gen_pkg::*;
#(
    parameter int ACC_WIDTH   = DEF_ACC_WIDTH,
    parameter int DEFAULT_INC = DEF_INC
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 run,
    input  logic                 load,
    input  logic [ACC_WIDTH-1:0] load_data,
    output logic                 ce
);

    logic [ACC_WIDTH-1:0] acc;
    logic [ACC_WIDTH-1:0] inc;
    logic [ACC_WIDTH:0]   sum;

    // One extra bit captures the carry that becomes the enable pulse.
    assign sum = {1'b0, acc} + {1'b0, inc};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
            inc <= ACC_WIDTH'(DEFAULT_INC);
            ce  <= 1'b0;
        end else begin
            if (run) begin
                acc <= sum[ACC_WIDTH-1:0];
                ce  <= sum[ACC_WIDTH];
            end else begin
                acc <= '0;
                ce  <= 1'b0;
            end
            // The sum above still uses the old increment at this edge.
            if (load) begin
                inc <= load_data;
            end
        end
    end

endmodule

// File: rtl/clock_enable_gen.sv
// Multi-channel clock-enable generator gated by PLL lock: waits for a run of
// consecutive locked cycles, then drives phase accumulators until lock drops.
module clock_enable_gen
    import clock_gen_pkg::*;
#(
    parameter int NUM_CH      = DEF_NUM_CH,
    parameter int ACC_WIDTH   = DEF_ACC_WIDTH,
    parameter int LOCK_CYCLES = DEF_LOCK_CYCLES,
    parameter int DEFAULT_INC = DEF_INC
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         pll_locked,
    input  logic                         wr_en,
    input  logic [idx_width(NUM_CH)-1:0] wr_ch,
    input  logic [ACC_WIDTH-1:0]         wr_data,
    output logic [NUM_CH-1:0]            ce,
    output logic                         ready,
    output logic                         lock_lost,
    input  logic                         lock_lost_clr
);

    localparam int CH_W  = idx_width(NUM_CH);
    localparam int CNT_W = $clog2(LOCK_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_CYCLES - 1);

    state_t           state;
    logic [CNT_W-1:0] settle_cnt;
    logic             run_en;

    // Accumulators advance only while in RUN with lock still present, so a
    // lock drop clears ce on the same edge that leaves RUN.
    assign run_en = (state == RUN) && pll_locked;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= WAIT_LOCK;
            settle_cnt <= '0;
            ready      <= 1'b0;
            lock_lost  <= 1'b0;
        end else begin
            case (state)
                WAIT_LOCK: begin
                    settle_cnt <= '0;
                    ready      <= 1'b0;
                    if (pll_locked) begin
                        state <= SETTLE;
                    end
                end
                SETTLE: begin
                    if (!pll_locked) begin
                        state      <= WAIT_LOCK;
                        settle_cnt <= '0;
                        ready      <= 1'b0;
                    end else if (settle_cnt == CNT_LAST) begin
                        state      <= RUN;
                        settle_cnt <= '0;
                        ready      <= 1'b1;
                    end else begin
                        settle_cnt <= settle_cnt + 1'b1;
                        ready      <= 1'b0;
                    end
                end
                RUN: begin
                    settle_cnt <= '0;
                    if (!pll_locked) begin
                        state <= WAIT_LOCK;
                        ready <= 1'b0;
                    end else begin
                        ready <= 1'b1;
                    end
                end
                default: begin
                    state      <= WAIT_LOCK;
                    settle_cnt <= '0;
                    ready      <= 1'b0;
                end
            endcase

            // A fresh lock loss outranks a clear arriving on the same edge.
            if ((state == RUN) && !pll_locked) begin
                lock_lost <= 1'b1;
            end else if (lock_lost_clr) begin
                lock_lost <= 1'b0;
            end
        end
    end

    // Out-of-range channel indices match no instance and are dropped.
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic load;
        assign load = wr_en && (wr_ch == CH_W'(i));

        phase_acc #(
            .ACC_WIDTH  (ACC_WIDTH),
            .DEFAULT_INC(DEFAULT_INC)
        ) u_phase_acc (
            .clk      (clk),
            .rst_n    (rst_n),
            .run      (run_en),
            .load     (load),
            .load_data(wr_data),
            .ce       (ce[i])
        );
    end

endmodule

// File: tb/tb_clock_enable_gen.sv
// Randomized and directed bench for clock_enable_gen against a lock-streak /
// integer-phase reference model.
module tb_clock_enable_gen;

    localparam int NUM_CH      = 5;
    localparam int ACC_WIDTH   = 8;
    localparam int LOCK_CYCLES = 4;
    localparam int DEFAULT_INC = 1;
    localparam int CH_W        = 3;
    localparam int MODULUS     = 256;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              pll_locked = 1'b0;
    logic              wr_en = 1'b0;
    logic [CH_W-1:0]   wr_ch = '0;
    logic [7:0]        wr_data = '0;
    logic [NUM_CH-1:0] ce;
    logic              ready;
    logic              lock_lost;
    logic              lock_lost_clr = 1'b0;

    always #5 clk = ~clk;

    clock_enable_gen #(
        .NUM_CH     (NUM_CH),
        .ACC_WIDTH  (ACC_WIDTH),
        .LOCK_CYCLES(LOCK_CYCLES),
        .DEFAULT_INC(DEFAULT_INC)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .pll_locked   (pll_locked),
        .wr_en        (wr_en),
        .wr_ch        (wr_ch),
        .wr_data      (wr_data),
        .ce           (ce),
        .ready        (ready),
        .lock_lost    (lock_lost),
        .lock_lost_clr(lock_lost_clr)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: ready follows the number of consecutive locked edges;
    // each channel phase is a plain integer modulo 2^ACC_WIDTH.
    int                m_inc[NUM_CH];
    int                m_phase[NUM_CH];
    logic [NUM_CH-1:0] m_ce;
    bit                m_ready;
    bit                m_ll;
    int                streak;
    int                pulse_cnt[NUM_CH];
    logic [NUM_CH-1:0] exp_q[$];

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < NUM_CH; c++) begin
            m_inc[c]   = DEFAULT_INC;
            m_phase[c] = 0;
        end
        m_ce    = '0;
        m_ready = 1'b0;
        m_ll    = 1'b0;
        streak  = 0;
    endtask

    task automatic clear_counts();
        for (int c = 0; c < NUM_CH; c++) pulse_cnt[c] = 0;
    endtask

    task automatic tick();
        bit was_ready;
        int total;
        was_ready = m_ready;
        @(posedge clk);
        for (int c = 0; c < NUM_CH; c++) begin
            if (was_ready && pll_locked) begin
                total      = m_phase[c] + m_inc[c];
                m_ce[c]    = (total >= MODULUS);
                m_phase[c] = total % MODULUS;
            end else begin
                m_phase[c] = 0;
                m_ce[c]    = 1'b0;
            end
        end
        if (was_ready && !pll_locked) m_ll = 1'b1;
        else if (lock_lost_clr) m_ll = 1'b0;
        streak  = pll_locked ? ((streak < 1000) ? streak + 1 : streak) : 0;
        m_ready = (streak >= LOCK_CYCLES + 1);
        if (wr_en && (int'(wr_ch) < NUM_CH)) m_inc[wr_ch] = int'(wr_data);
        exp_q.push_back(m_ce);
        #1;
        check_eq("ce", 32'(ce), 32'(exp_q.pop_front()));
        check_eq("ready", 32'(ready), 32'(m_ready));
        check_eq("lock_lost", 32'(lock_lost), 32'(m_ll));
        for (int c = 0; c < NUM_CH; c++) if (ce[c]) pulse_cnt[c]++;
    endtask

    task automatic set_inc(input int ch, input int val);
        wr_en   = 1'b1;
        wr_ch   = CH_W'(ch);
        wr_data = 8'(val);
        tick();
        wr_en   = 1'b0;
    endtask

    initial begin
        model_reset();
        clear_counts();
        #12;
        check_eq("reset_ce", 32'(ce), 0);
        check_eq("reset_ready", 32'(ready), 0);
        check_eq("reset_lock_lost", 32'(lock_lost), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Program increments while still waiting for lock.
        set_inc(0, 64);
        set_inc(1, 8'h80);
        set_inc(2, 8'hFF);
        set_inc(3, 0);
        set_inc(5, 8'h55);

        pll_locked = 1'b1;
        repeat (4) tick();
        check_eq("ready_early", 32'(ready), 0);
        tick();
        check_eq("ready_rise", 32'(ready), 1);
        check_eq("first_run_ce", 32'(ce), 0);
        tick();

        clear_counts();
        repeat (256) tick();
        check_eq("rate_ch0", pulse_cnt[0], 64);
        check_eq("rate_ch1", pulse_cnt[1], 128);
        check_eq("rate_ch2", pulse_cnt[2], 255);
        check_eq("rate_ch3", pulse_cnt[3], 0);
        check_eq("rate_ch4", pulse_cnt[4], 1);

        // Increment change mid-run; out-of-range write must be ignored.
        set_inc(0, 128);
        set_inc(NUM_CH, 8'h01);
        clear_counts();
        repeat (8) tick();
        check_eq("rate_ch0_after_write", pulse_cnt[0], 4);
        check_eq("rate_ch4_after_bad_write", pulse_cnt[4], 0);

        // Lock loss in RUN.
        pll_locked = 1'b0;
        tick();
        check_eq("drop_ready", 32'(ready), 0);
        check_eq("drop_ce", 32'(ce), 0);
        check_eq("drop_lock_lost", 32'(lock_lost), 1);
        pll_locked = 1'b1;
        repeat (6) tick();
        pll_locked    = 1'b0;
        lock_lost_clr = 1'b1;
        tick();
        check_eq("set_beats_clear", 32'(lock_lost), 1);
        tick();
        check_eq("clear_alone", 32'(lock_lost), 0);
        lock_lost_clr = 1'b0;

        // Lock drop during settling restarts the full wait.
        pll_locked = 1'b1;
        repeat (3) tick();
        pll_locked = 1'b0;
        tick();
        pll_locked = 1'b1;
        repeat (4) tick();
        check_eq("resettle_early", 32'(ready), 0);
        check_eq("resettle_no_lost", 32'(lock_lost), 0);
        tick();
        check_eq("resettle_ready", 32'(ready), 1);

        // Asynchronous reset in the middle of RUN.
        repeat (20) tick();
        rst_n = 1'b0;
        #1;
        check_eq("async_ce", 32'(ce), 0);
        check_eq("async_ready", 32'(ready), 0);
        check_eq("async_lock_lost", 32'(lock_lost), 0);
        model_reset();
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) tick();
        clear_counts();
        repeat (256) tick();
        check_eq("inc_restored_ch0", pulse_cnt[0], DEFAULT_INC);
        check_eq("inc_restored_ch3", pulse_cnt[3], DEFAULT_INC);

        // Randomized traffic.
        repeat (3000) begin
            pll_locked    = ($urandom_range(0, 99) >= 3);
            wr_en         = ($urandom_range(0, 9) == 0);
            wr_ch         = CH_W'($urandom_range(0, 7));
            wr_data       = 8'($urandom_range(0, 255));
            lock_lost_clr = ($urandom_range(0, 19) == 0);
            tick();
        end
        wr_en         = 1'b0;
        lock_lost_clr = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
